// File: rtl/pulpemu_trace_drain.sv
// Trace buffer drain engine: reads every valid trace entry over the buffer master port
// and streams it as a header word plus 32-bit data beats, then pulses trace_flushed_o.
module pulpemu_trace_drain #(
    parameter int unsigned NB_CORES         = 4,
    parameter int unsigned TRACE_BUFFER_DIM = 1024,
    parameter int unsigned MEM_RD_LAT       = 1,
    parameter logic [15:0] HDR_TAG          = 16'hA5A5
) (
    input  logic        ref_clk_i,
    input  logic        rst_ni,
    input  logic        trace_wait_i,
    input  logic        force_flush_i,
    input  logic [15:0] entry_count_i,
    output logic [31:0] trace_master_addr_o,
    output logic [31:0] trace_master_din_o,
    output logic        trace_master_we_o,
    input  logic [31:0] trace_master_dout_i,
    output logic [31:0] m_data_o,
    output logic        m_valid_o,
    output logic        m_last_o,
    input  logic        m_ready_i,
    output logic        trace_flushed_o,
    output logic        busy_o
);

    localparam int unsigned WPE      = NB_CORES * 4;
    localparam logic [15:0] DIM16    = 16'(TRACE_BUFFER_DIM);
    localparam logic [3:0]  WORD_MAX = 4'(WPE - 1);
    localparam logic [1:0]  LAT_MAX  = 2'(MEM_RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, HDR, REQ, WAIT, SEND, FLUSH} state_t;

    state_t      state_q, state_d;
    logic        wait_q, armed_q;
    logic [15:0] n_q, entry_q;
    logic [3:0]  word_q;
    logic [19:0] cnt_q;
    logic [19:0] w_last;
    logic [1:0]  lat_q;
    logic [31:0] data_q;
    logic        start, is_last;

    // armed_q keeps a trace_wait_i already high when reset releases from counting as an edge
    assign start   = (trace_wait_i & ~wait_q & armed_q) | force_flush_i;
    assign w_last  = 20'(n_q) * 20'(WPE) - 20'd1;
    assign is_last = (cnt_q == w_last);

    assign trace_master_addr_o = {10'b0, entry_q, word_q, 2'b00};
    assign trace_master_din_o  = '0;
    assign trace_master_we_o   = 1'b0;

    always_comb begin
        state_d         = state_q;
        m_valid_o       = 1'b0;
        m_data_o        = '0;
        m_last_o        = 1'b0;
        trace_flushed_o = 1'b0;
        busy_o          = (state_q != IDLE);
        case (state_q)
            IDLE: if (start) state_d = HDR;
            HDR: begin
                m_valid_o = 1'b1;
                m_data_o  = {HDR_TAG, n_q};
                m_last_o  = (n_q == '0);
                if (m_ready_i) state_d = (n_q == '0) ? FLUSH : REQ;
            end
            REQ:  state_d = WAIT;
            WAIT: if (lat_q == LAT_MAX) state_d = SEND;
            SEND: begin
                m_valid_o = 1'b1;
                m_data_o  = data_q;
                m_last_o  = is_last;
                if (m_ready_i) state_d = is_last ? FLUSH : REQ;
            end
            FLUSH: begin
                trace_flushed_o = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ref_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wait_q  <= 1'b0;
            armed_q <= 1'b0;
            n_q     <= '0;
            entry_q <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= trace_wait_i;
            armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q     <= (entry_count_i > DIM16) ? DIM16 : entry_count_i;
                        entry_q <= '0;
                        word_q  <= '0;
                        cnt_q   <= '0;
                    end
                end
                REQ: lat_q <= '0;
                WAIT: begin
                    lat_q <= lat_q + 2'd1;
                    if (lat_q == LAT_MAX) data_q <= trace_master_dout_i;
                end
                SEND: begin
                    if (m_ready_i && !is_last) begin
                        cnt_q <= cnt_q + 20'd1;
                        if (word_q == WORD_MAX) begin
                            word_q  <= '0;
                            entry_q <= entry_q + 16'd1;
                        end else begin
                            word_q <= word_q + 4'd1;
                        end
                    end
                end
                FLUSH: begin
                    entry_q <= '0;
                    word_q  <= '0;
                    cnt_q   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pulpemu_trace_drain.sv
// Directed, table-driven bench for pulpemu_trace_drain with a latency-accurate trace memory model.
`timescale 1ns/1ps
module tb_pulpemu_trace_drain;

    localparam int unsigned NB_CORES = 4;
    localparam int unsigned DIM      = 1024;
    localparam int unsigned LAT      = 1;
    localparam int unsigned WPE      = NB_CORES * 4;

    logic        ref_clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        trace_wait_i = 1'b0;
    logic        force_flush_i = 1'b0;
    logic [15:0] entry_count_i = '0;
    logic [31:0] trace_master_addr_o;
    logic [31:0] trace_master_din_o;
    logic        trace_master_we_o;
    logic [31:0] trace_master_dout_i;
    logic [31:0] m_data_o;
    logic        m_valid_o;
    logic        m_last_o;
    logic        m_ready_i = 1'b0;
    logic        trace_flushed_o;
    logic        busy_o;

    int checks = 0;
    int failures = 0;

    always #5 ref_clk_i = ~ref_clk_i;

    pulpemu_trace_drain #(
        .NB_CORES(NB_CORES),
        .TRACE_BUFFER_DIM(DIM),
        .MEM_RD_LAT(LAT),
        .HDR_TAG(16'hA5A5)
    ) dut (
        .ref_clk_i(ref_clk_i),
        .rst_ni(rst_ni),
        .trace_wait_i(trace_wait_i),
        .force_flush_i(force_flush_i),
        .entry_count_i(entry_count_i),
        .trace_master_addr_o(trace_master_addr_o),
        .trace_master_din_o(trace_master_din_o),
        .trace_master_we_o(trace_master_we_o),
        .trace_master_dout_i(trace_master_dout_i),
        .m_data_o(m_data_o),
        .m_valid_o(m_valid_o),
        .m_last_o(m_last_o),
        .m_ready_i(m_ready_i),
        .trace_flushed_o(trace_flushed_o),
        .busy_o(busy_o)
    );

    // Memory word = {entry[7:0], word[7:0], addr[15:0]}, delivered LAT cycles after the address
    function automatic logic [31:0] model(input logic [31:0] a);
        logic [15:0] e;
        e = a[21:6];
        return {e[7:0], 4'h0, a[5:2], a[15:0]};
    endfunction

    function automatic logic [31:0] beat_addr(input int unsigned k);
        return 32'((k / WPE) * 64 + (k % WPE) * 4);
    endfunction

    logic [31:0] pipe [LAT];
    always @(posedge ref_clk_i) begin
        pipe[0] <= model(trace_master_addr_o);
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign trace_master_dout_i = pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drain(input logic [15:0] cnt, input int trig, input bit thr, input int unsigned exp_n);
        int unsigned w_tot;
        int unsigned idx;
        int          budget;
        bit          done, stalled, held_l, rdy, early_flush, wr_seen, exp_l;
        logic [31:0] held_d, exp_d, max_addr;
        w_tot = exp_n * WPE;
        idx = 0;
        budget = int'((w_tot + 2) * (3 + LAT) * (thr ? 4 : 1)) + 20;
        done = 0; stalled = 0; held_l = 0; early_flush = 0; wr_seen = 0;
        held_d = '0; max_addr = '0;
        entry_count_i = cnt;
        trace_wait_i = 1'b0;
        force_flush_i = 1'b0;
        m_ready_i = 1'b0;
        @(negedge ref_clk_i);
        if (trig != 1) trace_wait_i = 1'b1;
        if (trig != 0) force_flush_i = 1'b1;
        @(negedge ref_clk_i);
        force_flush_i = 1'b0;
        chk("hdr_latency", 32'(m_valid_o), 32'd1);
        while (!done && !early_flush && budget > 0) begin
            budget--;
            if (trace_master_addr_o > max_addr) max_addr = trace_master_addr_o;
            if (trace_master_we_o || trace_master_din_o != '0) wr_seen = 1;
            if (trace_flushed_o) early_flush = 1;
            if (stalled) begin
                chk("stall_valid", 32'(m_valid_o), 32'd1);
                chk("stall_data", m_data_o, held_d);
                chk("stall_last", 32'(m_last_o), 32'(held_l));
            end
            rdy = thr ? ($urandom_range(0, 9) >= 3) : 1'b1;
            m_ready_i = rdy;
            if (m_valid_o) begin
                exp_l = (idx == w_tot);
                if (idx == 0) begin
                    exp_d = {16'hA5A5, 16'(exp_n)};
                    chk("hdr_data", m_data_o, exp_d);
                end else begin
                    exp_d = model(beat_addr(idx - 1));
                    chk("beat_data", m_data_o, exp_d);
                end
                chk("last_flag", 32'(m_last_o), 32'(exp_l));
                stalled = !rdy;
                held_d = m_data_o;
                held_l = m_last_o;
                if (rdy) begin
                    if (idx == w_tot) done = 1;
                    idx++;
                end
            end else begin
                stalled = 0;
            end
            if (idx > 0 && !done) entry_count_i = 16'($urandom);
            force_flush_i = !done && ($urandom_range(0, 7) == 0);
            @(negedge ref_clk_i);
        end
        force_flush_i = 1'b0;
        m_ready_i = 1'b0;
        chk("drain_done", 32'(done), 32'd1);
        chk("early_flush", 32'(early_flush), 32'd0);
        chk("beat_count", idx, w_tot + 1);
        chk("max_addr", max_addr, (w_tot == 0) ? 32'd0 : beat_addr(w_tot - 1));
        chk("no_write", 32'(wr_seen), 32'd0);
        chk("flush_pulse", 32'(trace_flushed_o), 32'd1);
        chk("busy_in_flush", 32'(busy_o), 32'd1);
        chk("valid_in_flush", 32'(m_valid_o), 32'd0);
        @(negedge ref_clk_i);
        chk("flush_once", 32'(trace_flushed_o), 32'd0);
        chk("busy_after", 32'(busy_o), 32'd0);
        repeat (3) @(negedge ref_clk_i);
        chk("no_retrigger", 32'(busy_o), 32'd0);
    endtask

    typedef struct {
        logic [15:0] cnt;
        int          trig;   // 0 wait edge, 1 force, 2 both together
        bit          thr;
        int unsigned exp_n;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int hs;
        int budget;
        bit busy_seen;
        vecs[0] = '{cnt: 16'd3,    trig: 0, thr: 1'b0, exp_n: 3};
        vecs[1] = '{cnt: 16'd0,    trig: 1, thr: 1'b0, exp_n: 0};
        vecs[2] = '{cnt: 16'd2000, trig: 0, thr: 1'b0, exp_n: 1024};
        vecs[3] = '{cnt: 16'd5,    trig: 0, thr: 1'b0, exp_n: 5};
        vecs[4] = '{cnt: 16'd5,    trig: 1, thr: 1'b1, exp_n: 5};
        vecs[5] = '{cnt: 16'd2,    trig: 2, thr: 1'b0, exp_n: 2};
        vecs[6] = '{cnt: 16'd1,    trig: 1, thr: 1'b1, exp_n: 1};

        rst_ni = 1'b0;
        repeat (3) @(negedge ref_clk_i);
        chk("rst_valid", 32'(m_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_flushed", 32'(trace_flushed_o), 32'd0);
        chk("rst_data", m_data_o, 32'd0);
        chk("rst_addr", trace_master_addr_o, 32'd0);
        rst_ni = 1'b1;
        @(negedge ref_clk_i);

        for (int v = 0; v < 7; v++)
            drain(vecs[v].cnt, vecs[v].trig, vecs[v].thr, vecs[v].exp_n);

        // Reset in the middle of a drain, after the header and ten data beats
        entry_count_i = 16'd4;
        trace_wait_i = 1'b0;
        @(negedge ref_clk_i);
        trace_wait_i = 1'b1;
        m_ready_i = 1'b1;
        hs = 0;
        budget = 200;
        while (hs < 11 && budget > 0) begin
            @(negedge ref_clk_i);
            budget--;
            if (m_valid_o) hs++;
        end
        chk("rst_mid_beats", 32'(hs), 32'd11);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", 32'(m_valid_o), 32'd0);
        chk("async_rst_busy", 32'(busy_o), 32'd0);
        chk("async_rst_last", 32'(m_last_o), 32'd0);
        chk("async_rst_data", m_data_o, 32'd0);
        chk("async_rst_addr", trace_master_addr_o, 32'd0);
        chk("async_rst_flushed", 32'(trace_flushed_o), 32'd0);
        m_ready_i = 1'b0;
        repeat (2) @(negedge ref_clk_i);
        rst_ni = 1'b1;
        busy_seen = 0;
        repeat (6) begin
            @(negedge ref_clk_i);
            if (busy_o || m_valid_o || trace_flushed_o) busy_seen = 1;
        end
        chk("no_start_wait_high", 32'(busy_seen), 32'd0);
        drain(16'd4, 0, 1'b0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
